terrain_scheduler: RTL and testbench
====================================

# terrain_scheduler

Frame-rate controller that sequences a pool of terrain sprite slots. It decides when each slot's movement enable (`ACTIVE`) is asserted. Each frame it spawns a new terrain segment into a free slot at a fixed frame interval and retires slots once their on-screen lifetime expires. It supports pause and graceful drain. It sits between game-state control and the terrain renderer instances, and its `o_active[k]` output drives instance k's `ACTIVE` input.

## Interface
- `NUM_SLOTS`, default 4: number of terrain instances managed (2..8).
- `SPAWN_INTERVAL`, default 90: frames between spawns (≥2).
- `LIFETIME`, default 360: frames a slot stays active after spawn (≥1, fits 16 bits).
- `i_clk` input, 1 bit: system clock; single clock domain.
- `i_rst_n` input, 1 bit: reset, asynchronous and active-low.
- `i_v_sync` input, 1 bit: vertical sync, asynchronous to `i_clk`; its rising edge marks a frame.
- `i_enable` input, 1 bit: game running; level-sensitive.
- `i_pause` input, 1 bit: freeze terrain; level-sensitive.
- `o_active` output, `NUM_SLOTS` bits: per-slot movement enable.
- `o_spawn` output, 1 bit: one-cycle pulse when a slot is spawned.
- `o_spawn_slot` output, `$clog2(NUM_SLOTS)` bits: index of the slot spawned; valid with `o_spawn`, holds its last value otherwise.
- `o_spawn_stall` output, 1 bit: a spawn is due but every slot is busy.
- `o_frame_cnt` output, 16 bits: frame ticks counted in RUN/DRAIN; wraps.
- `o_state` output, 2 bits: IDLE=0, RUN=1, PAUSE=2, DRAIN=3.

## Operation
- **Frame tick.** `i_v_sync` passes through a 2-FF synchronizer followed by a third register. `tick` = sync2 & ~sync3, a one-cycle pulse.
- **Internal state.**
  - per slot: `busy[k]` and `life[k]` (16 bits)
  - `spawn_cnt`, 0..`SPAWN_INTERVAL`-1
- **`o_active` rule.** `o_active[k]` = `busy[k]` when state is RUN or DRAIN; forced to 0 in IDLE and PAUSE.
- **IDLE.**
  - All `busy` are clear and `o_frame_cnt` is 0.
  - `i_enable`=1 → RUN. On entry, `spawn_cnt` ← `SPAWN_INTERVAL`-1, so the first tick spawns.
- **RUN**, on each tick, in this order:
  1. Expiry: for each busy slot, if `life`==1, clear `busy`; otherwise decrement `life`.
  2. Spawn: if `spawn_cnt`==`SPAWN_INTERVAL`-1:
     - If a free slot exists (including one freed in step 1), the lowest-index free slot is set busy with `life` ← `LIFETIME`. Then pulse `o_spawn`, load `o_spawn_slot`, and set `spawn_cnt` ← 0.
     - Otherwise, `spawn_cnt` holds and `o_spawn_stall`=1 until a spawn succeeds.
  3. Otherwise `spawn_cnt`+1.
  4. `o_frame_cnt`+1.
- **Transitions out of RUN.**
  - `i_pause`=1 → PAUSE. Pause has priority over `i_enable`=0.
  - `i_enable`=0 → DRAIN.
- **PAUSE.**
  - Ticks are ignored; all counters and `busy` are retained.
  - `i_pause`=0 → RUN if `i_enable`=1, else DRAIN.
- **DRAIN.**
  - Expiry and `o_frame_cnt` run as in RUN. There are no spawns, and `o_spawn_stall`=0.
  - When all `busy` are clear → IDLE.
  - `i_enable`=1 → RUN without resetting `spawn_cnt`.
  - `i_pause` is ignored.
- **Slot exclusivity.** A slot is never spawned while busy.

## Timing
- **Reset values** (async assert; takes effect immediately, mid-frame or mid-pause):
  - state IDLE
  - `o_active`=0, `o_spawn`=0, `o_spawn_slot`=0, `o_spawn_stall`=0, `o_frame_cnt`=0
  - all `busy` and `life` cleared; synchronizer registers 0
- **Latency.**
  - `i_v_sync` rising edge to `tick`: 3 `i_clk` edges.
  - All tick effects (expiry, spawn, `o_active`, `o_spawn`, counters) are registered and visible on the cycle after `tick`.
- **Pulse widths.**
  - `o_spawn` is exactly 1 cycle, at most once per frame.
  - `o_spawn_stall` is a level, updated only on ticks and on state changes.
- **State changes** take effect on the clock edge after the input change. `o_active` masking in PAUSE/IDLE follows `o_state` on the same cycle.
- **Wrap.** `o_frame_cnt` wraps 0xFFFF→0.
- **`tick` coinciding with a state change.** The tick is processed under the current (pre-transition) state.

## Test plan
- **Basic rotation** (NUM_SLOTS=2, SPAWN_INTERVAL=3, LIFETIME=5, enable at tick 0):
  - spawns slot0 at ticks 1 and 7, slot1 at ticks 4 and 10
  - slot0 active during ticks 1–5, expires on tick 6
  - `o_spawn` is a 1-cycle pulse each time.
- **Full pool** (LIFETIME=7, otherwise as above):
  - tick 7: `o_spawn_stall`=1, no spawn
  - tick 8: slot0 expires and is respawned on the same tick, stall clears
  - next spawn at tick 11.
- **Pause:**
  - pause for 10 frames mid-run → `o_active`=0, `life`, `spawn_cnt` and `o_frame_cnt` frozen
  - on resume, the schedule continues shifted by exactly 10 frames.
- **Drain:**
  - `i_enable`=0 with 2 busy slots → no further `o_spawn`; slots expire on schedule
  - state goes DRAIN→IDLE on the cycle after the last expiry
  - re-enable then spawns on the first tick.
- **Reset:**
  - `i_rst_n` low mid-cycle during RUN → all outputs 0 and `o_state`=0 immediately, with no clock.
- **Synchronizer latency:**
  - `i_v_sync` held high for 100 cycles produces exactly one tick
  - its effects appear on the 4th `i_clk` edge after the rise.

Source files
------------

// File: rtl/terrain_scheduler_if.sv
// Bus between game-state control and the terrain scheduler: frame sync, run/pause
// levels in, per-slot movement enables and spawn status out.
interface terrain_scheduler_if #(
   parameter int NUM_SLOTS = 4
);
   localparam int SW = $clog2(NUM_SLOTS);

   logic                 i_v_sync;
   logic                 i_enable;
   logic                 i_pause;
   logic [NUM_SLOTS-1:0] o_active;
   logic                 o_spawn;
   logic [SW-1:0]        o_spawn_slot;
   logic                 o_spawn_stall;
   logic [15:0]          o_frame_cnt;
   logic [1:0]           o_state;

   modport master (
      output i_v_sync, i_enable, i_pause,
      input  o_active, o_spawn, o_spawn_slot, o_spawn_stall, o_frame_cnt, o_state
   );

   modport slave (
      input  i_v_sync, i_enable, i_pause,
      output o_active, o_spawn, o_spawn_slot, o_spawn_stall, o_frame_cnt, o_state
   );
endinterface

// File: rtl/terrain_scheduler.sv
// Frame-rate controller for a pool of terrain sprite slots: spawns a segment every
// SPAWN_INTERVAL frames into the lowest free slot and retires it after LIFETIME frames.
module terrain_scheduler #(
   parameter int NUM_SLOTS      = 4,
   parameter int SPAWN_INTERVAL = 90,
   parameter int LIFETIME       = 360
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   terrain_scheduler_if.slave bus
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int CW = $clog2(SPAWN_INTERVAL);
   localparam logic [CW-1:0] SPAWN_LAST = CW'(SPAWN_INTERVAL - 1);
   localparam logic [15:0]   LIFE_INIT  = 16'(LIFETIME);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic                 sync1_q, sync2_q, sync3_q, tick_q;
   logic [1:0]           state_q, state_d;
   logic [NUM_SLOTS-1:0] busy_q, busy_d, busyExp;
   logic [15:0]          life_q [NUM_SLOTS];
   logic [15:0]          life_d [NUM_SLOTS];
   logic [CW-1:0]        spawnCnt_q, spawnCnt_d;
   logic [15:0]          frameCnt_q, frameCnt_d;
   logic                 spawn_q, spawn_d;
   logic [SW-1:0]        spawnSlot_q, spawnSlot_d;
   logic                 stall_q, stall_d;
   logic                 runLike, frameStep, freeFound;
   logic [SW-1:0]        freeIdx;

   assign runLike   = (state_q == RUN) || (state_q == DRAIN);
   assign frameStep = tick_q && runLike;

   // The extra tick register puts the frame pulse 3 edges after the v_sync rise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= bus.i_v_sync;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         tick_q  <= sync2_q & ~sync3_q;
      end
   end

   always_comb begin
      busyExp = busy_q;
      if (frameStep) begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (busy_q[k] && (life_q[k] == 16'd1)) busyExp[k] = 1'b0;
         end
      end
   end

   // Slots retired on this tick are already counted as free here.
   always_comb begin
      freeFound = 1'b0;
      freeIdx   = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (!busyExp[k]) begin
            freeFound = 1'b1;
            freeIdx   = SW'(k);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      life_d      = life_q;
      spawnCnt_d  = spawnCnt_q;
      frameCnt_d  = frameCnt_q;
      spawn_d     = 1'b0;
      spawnSlot_d = spawnSlot_q;
      stall_d     = stall_q;

      if (frameStep) begin
         busy_d     = busyExp;
         frameCnt_d = frameCnt_q + 16'd1;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (busy_q[k]) begin
               life_d[k] = (life_q[k] == 16'd1) ? 16'd0 : life_q[k] - 16'd1;
            end
         end
         if (state_q == RUN) begin
            if (spawnCnt_q == SPAWN_LAST) begin
               if (freeFound) begin
                  busy_d[freeIdx] = 1'b1;
                  life_d[freeIdx] = LIFE_INIT;
                  spawn_d         = 1'b1;
                  spawnSlot_d     = freeIdx;
                  spawnCnt_d      = '0;
                  stall_d         = 1'b0;
               end else begin
                  stall_d = 1'b1;
               end
            end else begin
               spawnCnt_d = spawnCnt_q + CW'(1);
            end
         end else begin
            stall_d = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (bus.i_enable) begin
               state_d    = RUN;
               spawnCnt_d = SPAWN_LAST;
            end
         end
         RUN: begin
            if (bus.i_pause)        state_d = PAUSE;
            else if (!bus.i_enable) state_d = DRAIN;
         end
         PAUSE: begin
            if (!bus.i_pause) state_d = bus.i_enable ? RUN : DRAIN;
         end
         default: begin
            if (bus.i_enable) begin
               state_d = RUN;
            end else if (busy_q == '0) begin
               state_d    = IDLE;
               frameCnt_d = '0;
            end
         end
      endcase

      if (state_d != state_q) stall_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         busy_q      <= '0;
         spawnCnt_q  <= '0;
         frameCnt_q  <= '0;
         spawn_q     <= 1'b0;
         spawnSlot_q <= '0;
         stall_q     <= 1'b0;
         for (int k = 0; k < NUM_SLOTS; k++) life_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         life_q      <= life_d;
         spawnCnt_q  <= spawnCnt_d;
         frameCnt_q  <= frameCnt_d;
         spawn_q     <= spawn_d;
         spawnSlot_q <= spawnSlot_d;
         stall_q     <= stall_d;
      end
   end

   assign bus.o_active      = runLike ? busy_q : '0;
   assign bus.o_spawn       = spawn_q;
   assign bus.o_spawn_slot  = spawnSlot_q;
   assign bus.o_spawn_stall = stall_q;
   assign bus.o_frame_cnt   = frameCnt_q;
   assign bus.o_state       = state_q;
endmodule

// File: tb/tb_terrain_scheduler.sv
// Directed bench: two schedulers (LIFETIME 5 and 7, 2 slots, interval 3) share one
// stimulus stream through rotation, stall, pause, drain, sync latency and reset.
module tb_terrain_scheduler;
   logic clk = 1'b0;
   logic rstN;
   logic vSync;
   logic enable;
   logic pause;

   int assertCount = 0;
   int failCount   = 0;

   // Expected values after tick t (index 0 unused), hand-derived from the slot schedule.
   int expActA   [12] = '{0, 1, 1, 1, 3, 3, 2, 3, 3, 1, 3, 3};
   int expSpawnA [12] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
   int expSlotA  [12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
   int expActB   [12] = '{0, 1, 1, 1, 3, 3, 3, 3, 3, 3, 3, 3};
   int expSpawnB [12] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
   int expSlotB  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
   int expStallB [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

   always #5 clk = ~clk;

   terrain_scheduler_if #(.NUM_SLOTS(2)) busA ();
   terrain_scheduler_if #(.NUM_SLOTS(2)) busB ();

   assign busA.i_v_sync = vSync;
   assign busA.i_enable = enable;
   assign busA.i_pause  = pause;
   assign busB.i_v_sync = vSync;
   assign busB.i_enable = enable;
   assign busB.i_pause  = pause;

   terrain_scheduler #(.NUM_SLOTS(2), .SPAWN_INTERVAL(3), .LIFETIME(5)) dutA (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .bus     (busA)
   );

   terrain_scheduler #(.NUM_SLOTS(2), .SPAWN_INTERVAL(3), .LIFETIME(7)) dutB (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .bus     (busB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic pa);
      @(negedge clk);
      enable = en;
      pause  = pa;
      @(negedge clk);
   endtask

   // Rise at a negedge; returns at the negedge following the 4th rising clock edge.
   task automatic runFrame();
      vSync = 1'b1;
      repeat (2) @(negedge clk);
      vSync = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic checkFrame(input string tag, input int st,
                             input int actA, input int spA, input int slA, input int stA,
                             input int actB, input int spB, input int slB, input int stB,
                             input int frame);
      checkOutput({tag, " A state"},  32'(busA.o_state),       st);
      checkOutput({tag, " A active"}, 32'(busA.o_active),      actA);
      checkOutput({tag, " A spawn"},  32'(busA.o_spawn),       spA);
      checkOutput({tag, " A slot"},   32'(busA.o_spawn_slot),  slA);
      checkOutput({tag, " A stall"},  32'(busA.o_spawn_stall), stA);
      checkOutput({tag, " A frame"},  32'(busA.o_frame_cnt),   frame);
      checkOutput({tag, " B state"},  32'(busB.o_state),       st);
      checkOutput({tag, " B active"}, 32'(busB.o_active),      actB);
      checkOutput({tag, " B spawn"},  32'(busB.o_spawn),       spB);
      checkOutput({tag, " B slot"},   32'(busB.o_spawn_slot),  slB);
      checkOutput({tag, " B stall"},  32'(busB.o_spawn_stall), stB);
      checkOutput({tag, " B frame"},  32'(busB.o_frame_cnt),   frame);
   endtask

   // One cycle later the spawn pulse must be gone; then let the synchronizer settle.
   task automatic pulseTail(input string tag);
      @(negedge clk);
      checkOutput({tag, " A spawn width"}, 32'(busA.o_spawn), 0);
      checkOutput({tag, " B spawn width"}, 32'(busB.o_spawn), 0);
      @(negedge clk);
   endtask

   initial begin
      rstN   = 1'b0;
      vSync  = 1'b0;
      enable = 1'b0;
      pause  = 1'b0;
      repeat (2) @(negedge clk);
      $display("[TB] reset state");
      checkFrame("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rstN = 1'b1;
      @(negedge clk);

      applyStimulus(1'b1, 1'b0);
      checkFrame("enable", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] rotation and full pool");
      for (int t = 1; t <= 11; t++) begin
         runFrame();
         checkFrame($sformatf("tick%0d", t), 1,
                    expActA[t], expSpawnA[t], expSlotA[t], 0,
                    expActB[t], expSpawnB[t], expSlotB[t], expStallB[t], t);
         pulseTail($sformatf("tick%0d", t));
      end

      $display("[TB] pause for 10 frames");
      applyStimulus(1'b1, 1'b1);
      checkFrame("pause entry", 2, 0, 0, 1, 0, 0, 0, 1, 0, 11);
      for (int p = 1; p <= 10; p++) begin
         runFrame();
         checkFrame($sformatf("paused%0d", p), 2, 0, 0, 1, 0, 0, 0, 1, 0, 11);
         pulseTail($sformatf("paused%0d", p));
      end
      applyStimulus(1'b1, 1'b0);
      checkFrame("resume", 1, 3, 0, 1, 0, 3, 0, 1, 0, 11);
      runFrame();
      checkFrame("tick12", 1, 2, 0, 1, 0, 3, 0, 1, 0, 12);
      pulseTail("tick12");
      runFrame();
      checkFrame("tick13", 1, 3, 1, 0, 0, 3, 0, 1, 0, 13);
      pulseTail("tick13");

      $display("[TB] drain");
      applyStimulus(1'b0, 1'b0);
      checkFrame("drain entry", 3, 3, 0, 0, 0, 3, 0, 1, 0, 13);
      runFrame();
      checkFrame("tick14", 3, 3, 0, 0, 0, 3, 0, 1, 0, 14);
      pulseTail("tick14");
      for (int t = 15; t <= 17; t++) begin
         runFrame();
         checkFrame($sformatf("tick%0d", t), 3, 1, 0, 0, 0, 2, 0, 1, 0, t);
         pulseTail($sformatf("tick%0d", t));
      end
      runFrame();
      checkFrame("tick18", 3, 0, 0, 0, 0, 0, 0, 1, 0, 18);
      @(negedge clk);
      checkOutput("drain to idle A state", 32'(busA.o_state), 0);
      checkOutput("drain to idle B state", 32'(busB.o_state), 0);
      checkOutput("drain to idle A frame", 32'(busA.o_frame_cnt), 0);
      checkOutput("drain to idle B frame", 32'(busB.o_frame_cnt), 0);
      @(negedge clk);

      $display("[TB] re-enable");
      applyStimulus(1'b1, 1'b0);
      checkFrame("re-enable", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      runFrame();
      checkFrame("retick1", 1, 1, 1, 0, 0, 1, 1, 0, 0, 1);
      pulseTail("retick1");

      $display("[TB] synchronizer latency");
      vSync = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("sync edge3 A frame", 32'(busA.o_frame_cnt), 1);
      @(negedge clk);
      checkOutput("sync edge4 A frame", 32'(busA.o_frame_cnt), 2);
      checkOutput("sync edge4 B frame", 32'(busB.o_frame_cnt), 2);
      repeat (96) @(negedge clk);
      vSync = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("sync single A frame", 32'(busA.o_frame_cnt), 2);
      checkOutput("sync single B frame", 32'(busB.o_frame_cnt), 2);

      runFrame();
      checkFrame("retick3", 1, 1, 0, 0, 0, 1, 0, 0, 0, 3);
      pulseTail("retick3");
      runFrame();
      checkFrame("retick4", 1, 3, 1, 1, 0, 3, 1, 1, 0, 4);

      $display("[TB] asynchronous reset mid-run");
      #2 rstN = 1'b0;
      #1;
      checkFrame("async reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
